// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Each digit is driven for CLK_DIV cycles. It is then followed by BLANK_CYC
// dead cycles with every anode off, so the previous digit's segments do not
// ghost onto the next one. Writes go into shadow registers. The shadow
// registers are copied into the display registers only at a frame boundary,
// so a frame never shows a mix of old and new digits.
//
// Ports
//   clock       in   1  system clock, rising-edge
//   reset       in   1  synchronous reset, active-low
//   wr_en       in   1  write strobe for shadow[wr_addr]
//   wr_addr     in   2  digit index (0 = rightmost)
//   wr_data     in   4  hex value to store
//   lz_blank    in   1  leading-zero blanking enable (live, every cycle)
//   sevenseg    out  7  active-low segments, bit0 = a ... bit6 = g
//   an          out  4  active-low digit enables, bit n = digit n
//   frame_done  out  1  one-cycle pulse on the first output cycle of digit 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 1000,  // 1..65535
  parameter int unsigned BLANK_CYC = 8      // 0..255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       lz_blank,
  output logic [6:0] sevenseg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam logic [0:0] ST_ACTIVE = 1'b0;
  localparam logic [0:0] ST_BLANK  = 1'b1;

  // Terminal timer values for each state. BLANK_LAST is only used when
  // BLANK_CYC is non-zero; the guard keeps the constant well-formed otherwise.
  localparam logic [15:0] ACTIVE_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] BLANK_LAST  = (BLANK_CYC > 0) ? 16'(BLANK_CYC - 1) : 16'd0;

  // -------------------------------------------------------------------------
  // Scan state
  // -------------------------------------------------------------------------
  logic [0:0]  state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] timer_reg, timer_next;
  logic        commit;

  logic [3:0]  display_val [4];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg + 16'd1;
    case (state_reg)
      ST_ACTIVE: begin
        if (timer_reg == ACTIVE_LAST) begin
          timer_next = 16'd0;
          if (BLANK_CYC == 0) begin
            // No dead time: move straight on to the next digit.
            idx_next = idx_reg + 2'd1;
          end else begin
            state_next = ST_BLANK;
          end
        end
      end
      default: begin
        if (timer_reg == BLANK_LAST) begin
          timer_next = 16'd0;
          state_next = ST_ACTIVE;
          idx_next   = idx_reg + 2'd1;
        end
      end
    endcase
  end

  // A frame boundary is the wrap from digit 3 back into digit 0's ACTIVE slot.
  // The idx only changes when a slot advances, so the wrap fully identifies it.
  assign commit = (state_next == ST_ACTIVE) && (idx_reg == 2'd3) && (idx_next == 2'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= ST_ACTIVE;
      idx_reg   <= 2'd0;
      timer_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow / display registers, one pair per digit
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic       wr_hit;
      logic [3:0] shadow_reg;
      logic [3:0] shadow_next;
      logic [3:0] display_reg;

      assign wr_hit      = wr_en && (wr_addr == 2'(gi));
      assign shadow_next = wr_hit ? wr_data : shadow_reg;

      // The commit copies shadow_next rather than shadow_reg. A write that
      // lands on the commit edge therefore joins the frame that is starting.
      always_ff @(posedge clock) begin
        if (!reset) begin
          shadow_reg  <= 4'd0;
          display_reg <= 4'd0;
        end else begin
          shadow_reg <= shadow_next;
          if (commit) begin
            display_reg <= shadow_next;
          end
        end
      end

      assign display_val[gi] = display_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Leading-zero detection
  // blank_mask[n] is set when digit n and every digit above it are zero.
  // Digit 0 is never a candidate, so that a value of zero still shows "0".
  // -------------------------------------------------------------------------
  logic [3:0] blank_mask;
  logic       lead_zero;

  always_comb begin
    blank_mask = 4'b0000;
    lead_zero  = 1'b1;
    for (int n = 3; n >= 1; n--) begin
      lead_zero     = lead_zero && (display_val[n] == 4'd0);
      blank_mask[n] = lead_zero;
    end
  end

  // -------------------------------------------------------------------------
  // Segment decode (active-low, g..a)
  // -------------------------------------------------------------------------
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Registered outputs. These reflect the scan state one cycle later.
  // -------------------------------------------------------------------------
  logic [3:0] an_reg, an_next;
  logic [6:0] seg_reg, seg_next;
  logic       frame_done_reg, frame_done_next;
  logic       digit_blank;

  assign digit_blank = lz_blank && blank_mask[idx_reg];

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    if ((state_reg == ST_ACTIVE) && !digit_blank) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = decode(display_val[idx_reg]);
    end
    // The first cycle of digit 0's slot. Digit 0 is never blanked, so the
    // pulse always lines up with the digit 0 anode going low.
    frame_done_next = (state_reg == ST_ACTIVE) && (idx_reg == 2'd0) && (timer_reg == 16'd0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      an_reg         <= 4'b1111;
      seg_reg        <= 7'b1111111;
      frame_done_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign an         = an_reg;
  assign sevenseg   = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Two instances are used.
//   dut_a  (CLK_DIV=4, BLANK_CYC=2) covers the full scenario: reset, writes,
//          commit timing, lz blanking, and a reset pulse mid-BLANK.
//   dut_b  (CLK_DIV=1, BLANK_CYC=0) covers the back-to-back scan.
//
// Each monitor collapses the output stream into runs of constant {an, seg}.
// A run counts as one transaction. Its length and frame_done placement are
// compared against hand-computed entries that the stimulus queued up front.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] len;
    logic        fd;
  } seg_t;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_7   = 7'b1111000;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_F   = 7'b0001110;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // dut_a signals
  logic       reset, wr_en, lz_blank;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [6:0] sevenseg;
  logic [3:0] an;
  logic       frame_done;

  // dut_b signals
  logic       b_reset, b_wr_en, b_lz_blank;
  logic [1:0] b_wr_addr;
  logic [3:0] b_wr_data;
  logic [6:0] b_sevenseg;
  logic [3:0] b_an;
  logic       b_frame_done;

  logic mon_a_en = 1'b0;
  logic mon_b_en = 1'b0;
  logic b_done   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  seg_t q_a[$];
  seg_t q_b[$];

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(2)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .lz_blank   (lz_blank),
    .sevenseg   (sevenseg),
    .an         (an),
    .frame_done (frame_done)
  );

  seg_scan_ctrl #(.CLK_DIV(1), .BLANK_CYC(0)) dut_b (
    .clock      (clock),
    .reset      (b_reset),
    .wr_en      (b_wr_en),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .lz_blank   (b_lz_blank),
    .sevenseg   (b_sevenseg),
    .an         (b_an),
    .frame_done (b_frame_done)
  );

  // ---------------------------------------------------------------- helpers
  task automatic push_a(input logic [3:0] a, input logic [6:0] s, input int len, input logic fd);
    seg_t e;
    e.an = a; e.seg = s; e.len = 16'(len); e.fd = fd;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] a, input logic [6:0] s, input int len, input logic fd);
    seg_t e;
    e.an = a; e.seg = s; e.len = 16'(len); e.fd = fd;
    q_b.push_back(e);
  endtask

  // One full, unblanked frame of dut_a: 4 active cycles then 2 blank cycles per digit.
  task automatic push_frame_a(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    push_a(4'b1110, s0, 4, 1'b1); push_a(4'b1111, S_OFF, 2, 1'b0);
    push_a(4'b1101, s1, 4, 1'b0); push_a(4'b1111, S_OFF, 2, 1'b0);
    push_a(4'b1011, s2, 4, 1'b0); push_a(4'b1111, S_OFF, 2, 1'b0);
    push_a(4'b0111, s3, 4, 1'b0); push_a(4'b1111, S_OFF, 2, 1'b0);
  endtask

  task automatic check_seg(input string tag, input int idx, input seg_t got, input seg_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s seg#%0d: got an=%b seg=%b len=%0d fd=%b, required an=%b seg=%b len=%0d fd=%b",
               tag, idx, got.an, got.seg, got.len, got.fd, exp.an, exp.seg, exp.len, exp.fd);
    end else begin
      $display("[TB] %s seg#%0d ok an=%b seg=%b len=%0d fd=%b", tag, idx, got.an, got.seg, got.len, got.fd);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic write(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  // ---------------------------------------------------------------- monitor A
  initial begin : mon_a
    logic [3:0] c_an;
    logic [6:0] c_seg;
    logic       fd_first;
    int         len, fd_cnt, nseg;
    seg_t       got, exp;
    len = 0; fd_cnt = 0; nseg = 0; fd_first = 1'b0; c_an = '0; c_seg = '0;
    forever begin
      @(negedge clock);
      if (!mon_a_en) begin
        len = 0;
      end else begin
        n_tests++;
        if (an !== 4'b1111 && $countones(~an) != 1) begin
          n_fail++;
          $display("FAIL A onehot: an=%b, required 1111 or a single low bit", an);
        end
        if (len != 0 && (an !== c_an || sevenseg !== c_seg)) begin
          got.an = c_an; got.seg = c_seg; got.len = 16'(len);
          got.fd = (fd_cnt == 0) ? 1'b0 : ((fd_cnt == 1 && fd_first) ? 1'b1 : 1'bx);
          if (q_a.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL A extra seg#%0d: got an=%b seg=%b len=%0d, required nothing", nseg, c_an, c_seg, len);
          end else begin
            exp = q_a.pop_front();
            check_seg("A", nseg, got, exp);
          end
          nseg++;
          len = 0;
        end
        if (len == 0) begin
          c_an = an; c_seg = sevenseg; fd_first = frame_done; fd_cnt = 0;
        end
        len++;
        if (frame_done !== 1'b0) fd_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- monitor B
  initial begin : mon_b
    logic [3:0] c_an;
    logic [6:0] c_seg;
    logic       fd_first;
    int         len, fd_cnt, nseg;
    seg_t       got, exp;
    len = 0; fd_cnt = 0; nseg = 0; fd_first = 1'b0; c_an = '0; c_seg = '0;
    forever begin
      @(negedge clock);
      if (!mon_b_en) begin
        len = 0;
      end else begin
        if (len != 0 && (b_an !== c_an || b_sevenseg !== c_seg)) begin
          got.an = c_an; got.seg = c_seg; got.len = 16'(len);
          got.fd = (fd_cnt == 0) ? 1'b0 : ((fd_cnt == 1 && fd_first) ? 1'b1 : 1'bx);
          if (q_b.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL B extra seg#%0d: got an=%b seg=%b len=%0d, required nothing", nseg, c_an, c_seg, len);
          end else begin
            exp = q_b.pop_front();
            check_seg("B", nseg, got, exp);
          end
          nseg++;
          len = 0;
        end
        if (len == 0) begin
          c_an = b_an; c_seg = b_sevenseg; fd_first = b_frame_done; fd_cnt = 0;
        end
        len++;
        if (b_frame_done !== 1'b0) fd_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus B
  initial begin : stim_b
    b_reset = 1'b0; b_wr_en = 1'b0; b_wr_addr = 2'd0; b_wr_data = 4'd0; b_lz_blank = 1'b0;
    // Two reset cycles are observed, then digits step every cycle with no blank gap.
    push_b(4'b1111, S_OFF, 2, 1'b0);
    for (int f = 0; f < 12; f++) begin
      push_b(4'b1110, S_0, 1, 1'b1);
      push_b(4'b1101, S_0, 1, 1'b0);
      push_b(4'b1011, S_0, 1, 1'b0);
      push_b(4'b0111, S_0, 1, 1'b0);
    end
    @(posedge clock); #1; mon_b_en = 1'b1;
    @(posedge clock); #1; b_reset = 1'b1;
    for (int i = 0; i < 200 && q_b.size() != 0; i++) @(posedge clock);
    if (q_b.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL B timeout: %0d segments outstanding, required 0", q_b.size());
    end
    #1;
    mon_b_en = 1'b0;
    b_done   = 1'b1;
  end

  // ---------------------------------------------------------------- stimulus A
  initial begin : stim_a
    reset = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0; lz_blank = 1'b0;

    // Expected output runs, derived by hand for CLK_DIV=4 / BLANK_CYC=2
    // (24-cycle frames; output cycle 0 is the first cycle after release).
    push_a(4'b1111, S_OFF, 4, 1'b0);            // reset state
    push_frame_a(S_0, S_0, S_0, S_0);           // F0  cycles   0..23
    push_frame_a(S_0, S_0, S_0, S_0);           // F1  writes land but are not shown
    push_frame_a(S_F, S_0, S_5, S_A);           // F2  commit of 3:A 2:5 1:0 0:F
    push_frame_a(S_F, S_7, S_5, S_A);           // F3  write on the commit edge shows
    push_frame_a(S_F, S_7, S_3, S_A);           // F4  write one cycle late shows here
    push_a(4'b1110, S_0, 4, 1'b1);              // F5  0,0,7,0 with lz_blank=1
    push_a(4'b1111, S_OFF, 2, 1'b0);
    push_a(4'b1101, S_7, 4, 1'b0);
    push_a(4'b1111, S_OFF, 14, 1'b0);           //     digits 3,2 dark plus blanks
    push_frame_a(S_0, S_7, S_0, S_0);           // F6  lz_blank dropped mid-frame
    push_a(4'b1110, S_0, 4, 1'b1);              // F7  aborted by reset
    push_a(4'b1111, S_OFF, 2, 1'b0);
    push_a(4'b1101, S_7, 4, 1'b0);
    push_a(4'b1111, S_OFF, 2, 1'b0);
    push_a(4'b1011, S_0, 4, 1'b0);
    push_a(4'b1111, S_OFF, 3, 1'b0);            //     reset held 3 cycles
    push_frame_a(S_0, S_0, S_0, S_0);           // R0  restart, display cleared
    push_frame_a(S_0, S_0, S_0, S_0);           // R1  shadow cleared, reset-cycle write lost

    @(posedge clock); #1; mon_a_en = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    cyc   = 0;

    goto(30);  write(2'd3, 4'hA);
    goto(31);  write(2'd2, 4'h5);
    goto(32);  write(2'd1, 4'h0);
    goto(33);  write(2'd0, 4'hF);
    goto(34);  wr_en = 1'b0;

    goto(71);  write(2'd1, 4'h7);               // same edge as the F3 commit
    goto(72);  write(2'd2, 4'h3);               // first cycle of F3: too late for it
    goto(73);  wr_en = 1'b0;

    goto(100); write(2'd3, 4'h0);
    goto(101); write(2'd2, 4'h0);
    goto(102); write(2'd0, 4'h0);
    goto(103); wr_en = 1'b0; lz_blank = 1'b1;

    goto(150); lz_blank = 1'b0;

    goto(184); reset = 1'b0; write(2'd0, 4'h9); // first BLANK cycle of digit 2
    goto(185); wr_en = 1'b0;
    goto(187); reset = 1'b1;

    goto(236);
    for (int i = 0; i < 100 && q_a.size() != 0; i++) @(posedge clock);
    if (q_a.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL A timeout: %0d segments outstanding, required 0", q_a.size());
    end
    #1;
    mon_a_en = 1'b0;

    for (int i = 0; i < 500 && !b_done; i++) @(posedge clock);
    if (!b_done) begin
      n_tests++; n_fail++;
      $display("FAIL B done: got 0, required 1");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1000: cycles each digit is driven per scan slot; legal range 1..65535.
REQ-002 Parameter BLANK_CYC, default 8: dead cycles after each digit with all anodes off; legal range 0..255.
REQ-003 clock  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-low.
REQ-005 wr_en  in  1  write strobe for the shadow digit register selected by wr_addr.
REQ-006 wr_addr  in  2  digit index; 0 is the rightmost digit.
REQ-007 wr_data  in  4  hex value to write.
REQ-008 lz_blank  in  1  leading-zero blanking enable, sampled every cycle.
REQ-009 sevenseg  out  7  active-low segments; bit0=a … bit6=g.
REQ-010 an  out  4  active-low digit enables; bit n selects digit n.
REQ-011 frame_done  out  1  one-cycle pulse when a new scan frame starts.

Function
REQ-012 The block SHALL hold four 4-bit shadow registers and four 4-bit display registers.
REQ-013 A write with wr_en=1 SHALL update shadow[wr_addr] at the clock edge; display registers are not written directly.
REQ-014 The FSM SHALL have two states, ACTIVE and BLANK, plus a 2-bit digit index idx and a 16-bit timer.
REQ-015 In ACTIVE the timer SHALL count 0..CLK_DIV-1, then go to BLANK with timer=0; if BLANK_CYC=0 it SHALL go straight to the next digit's ACTIVE.
REQ-016 In BLANK the timer SHALL count 0..BLANK_CYC-1, then return to ACTIVE with idx+1 mod 4 and timer=0.
REQ-017 Each digit slot SHALL therefore last exactly CLK_DIV+BLANK_CYC cycles, and a frame SHALL last 4×(CLK_DIV+BLANK_CYC) cycles.
REQ-018 On each idx 3->0 transition into ACTIVE (frame boundary), all shadow registers SHALL be copied into the display registers.
REQ-019 A write in the same cycle as the commit SHALL be included in that commit.
REQ-020 Outputs SHALL be registered, reflecting state/idx/display one cycle later (latency 1).
REQ-021 In ACTIVE, an SHALL equal ~(1<<idx) and sevenseg SHALL equal decode(display[idx]), unless the digit is blanked per REQ-023.
REQ-022 In BLANK, an SHALL be 4'b1111 and sevenseg SHALL be 7'b1111111.
REQ-023 With lz_blank=1, digit n (n=3..1) SHALL be blanked (an=1111, seg=1111111) when display[n] and every higher display digit are 0; digit 0 is never blanked.
REQ-024 Decode (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-025 frame_done SHALL be 1 for exactly the output cycle in which digit 0's slot begins (including the first slot after reset) and 0 otherwise.
REQ-026 Only one digit SHALL ever be enabled on an at any time.

Reset
REQ-027 While reset=0: state=ACTIVE, idx=0, timer=0, all shadow and display registers 0, an=1111, sevenseg=1111111, frame_done=0.
REQ-028 Reset asserted mid-slot or mid-BLANK SHALL abort the scan at the next edge with no commit; a write in the same cycle as reset SHALL be discarded.
REQ-029 In the first cycle after reset release, the digit 0 slot SHALL begin: an=1110, sevenseg=1000000 and frame_done=1 in the following cycle, and no commit occurs for that slot.

Verification (CLK_DIV=4, BLANK_CYC=2 unless noted)
REQ-030 Release reset, no writes -> an cycles through 1110(4 cycles), 1111(2), 1101(4), 1111(2), … with seg 1000000 whenever an≠1111; frame_done every 24 cycles.
REQ-031 Write 3:A,2:5,1:0,0:F mid-frame -> display unchanged until the next frame; then digit3=0001000, digit2=0010010, digit1=1000000, digit0=0001110.
REQ-032 Write at the exact commit cycle -> the value appears in the frame that starts at that commit.
REQ-033 lz_blank=1 with digits 0,0,7,0 -> digits 3 and 2 show an=1111, digit1=1111000, digit0=1000000; toggling lz_blank to 0 restores digits 3 and 2 on their next slot.
REQ-034 BLANK_CYC=0, CLK_DIV=1 -> an steps 1110,1101,1011,0111 on consecutive cycles and never shows 1111.
REQ-035 Reset pulsed mid-BLANK of digit 2 -> outputs 1111/1111111 during reset, the digit 0 slot restarts per REQ-029, and display registers read 0.
